// File: rtl/jtag_tap_ctrl_if.sv
// JTAG pin bundle: tms/tdi driven by the probe side, tdo/tdo_oe driven by the TAP.
interface jtag_tap_ctrl_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// Parametrised IEEE 1149.1 TAP controller: 16-state FSM, IR, and the
// BYPASS / IDCODE / USER data registers. USER has parallel capture and
// update hooks for SoC debug logic.
module jtag_tap_ctrl #(
  parameter int                    IR_LEN       = 4,
  parameter logic [31:0]           IDCODE_VAL   = 32'h1000_0001,
  parameter int                    USER_DR_LEN  = 8,
  parameter logic [IR_LEN-1:0]     IDCODE_INSTR = IR_LEN'(1),
  parameter logic [IR_LEN-1:0]     USER_INSTR   = IR_LEN'(2)
) (
  input  logic                   tck,
  input  logic                   trst_n,
  jtag_tap_ctrl_if.slave         jtag,
  output logic [3:0]             state,
  output logic [IR_LEN-1:0]      instruction,
  input  logic [USER_DR_LEN-1:0] user_dr_in,
  output logic [USER_DR_LEN-1:0] user_dr_out,
  output logic                   user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state_reg, state_next;

  logic [IR_LEN-1:0]      ir_sr_reg;
  logic [IR_LEN-1:0]      instruction_reg;
  logic                   bypass_reg;
  logic [31:0]            idcode_sr_reg;
  logic [USER_DR_LEN-1:0] user_sr_reg;
  logic [USER_DR_LEN-1:0] user_dr_out_reg;
  logic                   user_update_reg;
  logic                   tdo_reg, tdo_next;
  logic                   tdo_oe_reg, tdo_oe_next;

  logic sel_idcode, sel_user;
  logic [USER_DR_LEN-1:0] user_shift;

  assign sel_idcode = (instruction_reg == IDCODE_INSTR);
  assign sel_user   = (instruction_reg == USER_INSTR);

  // USER shift-right path built bitwise so a 1-bit register needs no special case.
  assign user_shift[USER_DR_LEN-1] = jtag.tdi;
  generate
    for (genvar gi = 0; gi < USER_DR_LEN - 1; gi++) begin : g_user_shift
      assign user_shift[gi] = user_sr_reg[gi+1];
    end
  endgenerate

  // TAP state register.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_reg <= TLR;
    else         state_reg <= state_next;
  end

  // TAP next-state decode from tms.
  always_comb begin
    state_next = TLR;
    case (state_reg)
      TLR:     state_next = jtag.tms ? TLR    : RTI;
      RTI:     state_next = jtag.tms ? SEL_DR : RTI;
      SEL_DR:  state_next = jtag.tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:   state_next = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next = jtag.tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = jtag.tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next = jtag.tms ? SEL_DR : RTI;
      SEL_IR:  state_next = jtag.tms ? TLR    : CAP_IR;
      CAP_IR:  state_next = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:   state_next = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next = jtag.tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = jtag.tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next = jtag.tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Instruction shift register: capture the mandatory 01 pattern, shift LSB first.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr_reg <= '0;
    end else if (state_reg == CAP_IR) begin
      ir_sr_reg <= IR_LEN'(1);
    end else if (state_reg == SH_IR) begin
      ir_sr_reg <= {jtag.tdi, ir_sr_reg[IR_LEN-1:1]};
    end
  end

  // Active instruction: held at IDCODE while in TLR, loaded in UPD_IR.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      instruction_reg <= IDCODE_INSTR;
    end else if (state_reg == TLR) begin
      instruction_reg <= IDCODE_INSTR;
    end else if (state_reg == UPD_IR) begin
      instruction_reg <= ir_sr_reg;
    end
  end

  // BYPASS register: only moves when neither IDCODE nor USER is selected.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_reg <= 1'b0;
    end else if (!sel_idcode && !sel_user) begin
      if (state_reg == CAP_DR)     bypass_reg <= 1'b0;
      else if (state_reg == SH_DR) bypass_reg <= jtag.tdi;
    end
  end

  // IDCODE register: capture the fixed id, shift right with tdi into bit 31.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_sr_reg <= '0;
    end else if (sel_idcode) begin
      if (state_reg == CAP_DR)     idcode_sr_reg <= IDCODE_VAL;
      else if (state_reg == SH_DR) idcode_sr_reg <= {jtag.tdi, idcode_sr_reg[31:1]};
    end
  end

  // USER register: parallel capture from SoC, serial shift, parallel update to SoC.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      user_sr_reg     <= '0;
      user_dr_out_reg <= '0;
      user_update_reg <= 1'b0;
    end else begin
      user_update_reg <= 1'b0;
      if (sel_user) begin
        case (state_reg)
          CAP_DR: user_sr_reg <= user_dr_in;
          SH_DR:  user_sr_reg <= user_shift;
          UPD_DR: begin
            user_dr_out_reg <= user_sr_reg;
            user_update_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Serial output select; only the two shift states drive the pin.
  always_comb begin
    tdo_next    = 1'b0;
    tdo_oe_next = 1'b0;
    case (state_reg)
      SH_IR: begin
        tdo_next    = ir_sr_reg[0];
        tdo_oe_next = 1'b1;
      end
      SH_DR: begin
        tdo_oe_next = 1'b1;
        if (sel_idcode)    tdo_next = idcode_sr_reg[0];
        else if (sel_user) tdo_next = user_sr_reg[0];
        else               tdo_next = bypass_reg;
      end
      default: ;
    endcase
  end

  // tdo changes on falling tck so the probe samples a stable bit on the rising edge.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_next;
      tdo_oe_reg <= tdo_oe_next;
    end
  end

  assign jtag.tdo    = tdo_reg;
  assign jtag.tdo_oe = tdo_oe_reg;
  assign state       = state_reg;
  assign instruction = instruction_reg;
  assign user_dr_out = user_dr_out_reg;
  assign user_update = user_update_reg;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: IDCODE read, IR load, USER write/read,
// BYPASS, pause/resume and asynchronous reset.
module tb_jtag_tap_ctrl;

  logic       tck;
  logic       trst_n;
  logic [3:0] state;
  logic [3:0] instruction;
  logic [7:0] user_dr_in;
  logic [7:0] user_dr_out;
  logic       user_update;

  int checks = 0;
  int errors = 0;

  jtag_tap_ctrl_if jtag ();

  jtag_tap_ctrl #(
    .IR_LEN       (4),
    .IDCODE_VAL   (32'h1000_0001),
    .USER_DR_LEN  (8),
    .IDCODE_INSTR (4'd1),
    .USER_INSTR   (4'd2)
  ) dut (
    .tck         (tck),
    .trst_n      (trst_n),
    .jtag        (jtag.slave),
    .state       (state),
    .instruction (instruction),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One tck cycle: drive pins, sample tdo after the falling edge, return after the rising edge.
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jtag.tms = tms_v;
    jtag.tdi = tdi_v;
    @(negedge tck);
    #1 tdo_v = jtag.tdo;
    @(posedge tck);
    #1;
  endtask

  // From RTI: load a 4-bit IR and return to RTI; cap gets the captured tdo bits.
  task automatic shift_ir(input logic [3:0] val, output logic [3:0] cap);
    logic t;
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i], t);
      cap[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  // From RTI: shift len DR bits LSB first, pass through UPD_DR, return to RTI.
  task automatic shift_dr(input logic [31:0] val, input int len, output logic [31:0] cap);
    logic t;
    cap = '0;
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, val[i], t);
      cap[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  initial begin
    logic        t;
    logic [3:0]  ir_cap;
    logic [31:0] dr_cap;
    logic [7:0]  pat;
    logic [3:0]  ir_codes [2];

    trst_n     = 1'b0;
    jtag.tms   = 1'b1;
    jtag.tdi   = 1'b0;
    user_dr_in = 8'h00;
    #12 trst_n = 1'b1;
    #1;

    // Reset state
    check_val("rst_state", 32'(state), 32'hF);
    check_val("rst_instr", 32'(instruction), 32'h1);
    check_val("rst_tdo", 32'(jtag.tdo), 32'h0);
    check_val("rst_tdo_oe", 32'(jtag.tdo_oe), 32'h0);
    check_val("rst_user_out", 32'(user_dr_out), 32'h0);
    check_val("rst_user_upd", 32'(user_update), 32'h0);

    @(posedge tck);
    #1;

    // IDCODE read: F -> C -> 7 -> 6 -> 2
    step(1'b0, 1'b0, t); check_val("seq_rti", 32'(state), 32'hC);
    step(1'b1, 1'b0, t); check_val("seq_seldr", 32'(state), 32'h7);
    step(1'b0, 1'b0, t); check_val("seq_capdr", 32'(state), 32'h6);
    step(1'b0, 1'b0, t); check_val("seq_shdr", 32'(state), 32'h2);
    dr_cap = '0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0, t);
      dr_cap[i] = t;
      if (i == 0) check_val("idcode_tdo_oe", 32'(jtag.tdo_oe), 32'h1);
    end
    check_val("idcode_value", dr_cap, 32'h1000_0001);
    check_val("idcode_ex1", 32'(state), 32'h1);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    check_val("idcode_no_upd", 32'(user_update), 32'h0);

    // Five tms=1 edges from SH_DR reach TLR
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    check_val("tlr_from_shdr_pre", 32'(state), 32'h2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    check_val("tlr_state", 32'(state), 32'hF);
    check_val("tlr_instr", 32'(instruction), 32'h1);
    step(1'b0, 1'b0, t);

    // IR capture and load USER
    shift_ir(4'b0010, ir_cap);
    check_val("ir_capture", 32'(ir_cap), 32'h1);
    check_val("ir_load_user", 32'(instruction), 32'h2);

    // USER write/read with update pulse
    user_dr_in = 8'h3C;
    shift_dr(32'hA5, 8, dr_cap);
    check_val("user_capture", dr_cap, 32'h3C);
    check_val("user_out", 32'(user_dr_out), 32'hA5);
    check_val("user_upd_pulse", 32'(user_update), 32'h1);
    step(1'b0, 1'b0, t);
    check_val("user_upd_clear", 32'(user_update), 32'h0);

    // TLR forces IDCODE back into the instruction register
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    check_val("tlr_reload_instr", 32'(instruction), 32'h1);
    step(1'b0, 1'b0, t);

    // BYPASS via all-ones and via an undecoded opcode
    ir_codes[0] = 4'hF;
    ir_codes[1] = 4'h7;
    for (int k = 0; k < 2; k++) begin
      shift_ir(ir_codes[k], ir_cap);
      check_val($sformatf("bp_instr_%0d", k), 32'(instruction), 32'(ir_codes[k]));
      shift_dr(32'b1101, 4, dr_cap);
      check_val($sformatf("bp_delay_%0d", k), dr_cap, 32'b1010);
      check_val($sformatf("bp_user_hold_%0d", k), 32'(user_dr_out), 32'hA5);
      check_val($sformatf("bp_no_upd_%0d", k), 32'(user_update), 32'h0);
    end

    // USER shift interrupted by a pause
    shift_ir(4'h2, ir_cap);
    user_dr_in = 8'hC3;
    pat = 8'h5A;
    dr_cap = '0;
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, pat[i], t);
      dr_cap[i] = t;
    end
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b1, t);
    check_val("pause_state", 32'(state), 32'h3);
    check_val("pause_tdo_oe", 32'(jtag.tdo_oe), 32'h0);
    step(1'b1, 1'b0, t);
    check_val("pause_ex2", 32'(state), 32'h0);
    step(1'b0, 1'b0, t);
    for (int i = 4; i < 8; i++) begin
      step(i == 7, pat[i], t);
      dr_cap[i] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    check_val("pause_capture", dr_cap, 32'hC3);
    check_val("pause_user_out", 32'(user_dr_out), 32'h5A);

    // Asynchronous reset in the middle of a USER shift
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, t);
    @(negedge tck);
    #2;
    check_val("areset_pre_oe", 32'(jtag.tdo_oe), 32'h1);
    trst_n = 1'b0;
    #1;
    check_val("areset_state", 32'(state), 32'hF);
    check_val("areset_user_out", 32'(user_dr_out), 32'h0);
    check_val("areset_tdo_oe", 32'(jtag.tdo_oe), 32'h0);
    check_val("areset_tdo", 32'(jtag.tdo), 32'h0);
    check_val("areset_instr", 32'(instruction), 32'h1);
    #1 trst_n = 1'b1;
    jtag.tms = 1'b1;
    @(posedge tck);
    #1;
    check_val("areset_hold_tlr", 32'(state), 32'hF);
    check_val("areset_no_upd", 32'(user_update), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
